mnist_param_sequencer: RTL and testbench

MNIST_PARAM_SEQUENCER -- requirements
Module: mnist_param_sequencer

---
 rtl/mnist_param_sequencer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_mnist_param_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mnist_param_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : mnist_param_sequencer
// Brief   : CPU-programmable write table.
//           A kick or a start-of-frame replays the table as Wishbone master
//           writes to the CNN/color parameter bus.
// Revision: 1.0 - initial release
// ============================================================================
module mnist_param_sequencer #(
    parameter int WB_ADR_WIDTH = 8,
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8,
    parameter int TABLE_NUM    = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    wb_rst_i,

    input  logic [WB_ADR_WIDTH-1:0] s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] s_wb_dat_i,
    input  logic                    s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0] s_wb_sel_i,
    input  logic                    s_wb_stb_i,
    output logic [WB_DAT_WIDTH-1:0] s_wb_dat_o,
    output logic                    s_wb_ack_o,

    input  logic                    frame_tuser,
    input  logic                    frame_tvalid,
    input  logic                    frame_tready,

    output logic [WB_ADR_WIDTH-1:0] m_wb_adr_o,
    output logic [WB_DAT_WIDTH-1:0] m_wb_dat_o,
    output logic                    m_wb_we_o,
    output logic [WB_SEL_WIDTH-1:0] m_wb_sel_o,
    output logic                    m_wb_stb_o,
    input  logic                    m_wb_ack_i,

    output logic                    busy_o,
    output logic                    error_o
);

    localparam int IDX_W  = (TABLE_NUM > 1) ? $clog2(TABLE_NUM) : 1;
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_CTRL   = WB_ADR_WIDTH'(8'h00);
    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_STATUS = WB_ADR_WIDTH'(8'h01);
    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_NUM    = WB_ADR_WIDTH'(8'h02);
    localparam logic [WB_ADR_WIDTH-1:0] c_ADR_ENTRY  = WB_ADR_WIDTH'(8'h10);
    localparam logic [WB_ADR_WIDTH-1:0] c_TABLE_NUM  = WB_ADR_WIDTH'(TABLE_NUM);
    localparam logic [4:0]              c_NUM_MAX    = 5'(TABLE_NUM);
    localparam logic [WAIT_W-1:0]       c_WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic                       r_sync_en;
    logic [4:0]                 r_num;
    logic                       r_error;
    logic                       r_overrun;
    logic [7:0]                 r_done_cnt;
    logic [IDX_W-1:0]           r_index;
    logic [WAIT_W-1:0]          r_wait;

    logic [WB_ADR_WIDTH-1:0]    r_tab_adr [TABLE_NUM];
    logic [3:0]                 r_tab_sel [TABLE_NUM];
    logic [WB_DAT_WIDTH-1:0]    r_tab_dat [TABLE_NUM];

    logic                       w_busy;
    logic                       w_issue;
    logic                       w_wr;
    logic                       w_kick;
    logic                       w_frame;
    logic                       w_trigger;
    logic                       w_stat_wr;
    logic [WB_ADR_WIDTH-1:0]    w_off;
    logic [WB_ADR_WIDTH-1:0]    w_ent_num;
    logic                       w_ent_hit;
    logic [IDX_W-1:0]           w_ent_idx;
    logic [WB_DAT_WIDTH-1:0]    w_bmask;
    logic [WB_DAT_WIDTH-1:0]    w_rd;
    logic [WB_DAT_WIDTH-1:0]    w_wr_merged;
    logic [4:0]                 w_num_sat;
    logic [WB_SEL_WIDTH+3:0]    w_sel_wide;

    logic                       w_idx_clr;
    logic                       w_idx_inc;
    logic                       w_wait_clr;
    logic                       w_wait_inc;
    logic                       w_done_inc;
    logic                       w_timeout;

    assign w_busy  = (r_state != S_IDLE);
    assign w_issue = (r_state == S_ISSUE);

    // Slave-port address decode; table entries are interleaved adr/dat pairs
    assign w_wr      = s_wb_stb_i & s_wb_we_i;
    assign w_off     = s_wb_adr_i - c_ADR_ENTRY;
    assign w_ent_num = w_off >> 1;
    assign w_ent_hit = (s_wb_adr_i >= c_ADR_ENTRY) && (w_ent_num < c_TABLE_NUM);
    assign w_ent_idx = w_ent_num[IDX_W-1:0];

    assign w_kick    = w_wr && (s_wb_adr_i == c_ADR_CTRL) && s_wb_sel_i[0] && s_wb_dat_i[1];
    assign w_frame   = r_sync_en & frame_tvalid & frame_tready & frame_tuser;
    assign w_trigger = w_kick | w_frame;
    assign w_stat_wr = w_wr && (s_wb_adr_i == c_ADR_STATUS) && s_wb_sel_i[0];

    // Expand byte selects into a bit mask for read-modify-write merging
    always_comb begin
        w_bmask = '0;
        for (int b = 0; b < WB_SEL_WIDTH; b++) begin
            w_bmask[b*8 +: 8] = {8{s_wb_sel_i[b]}};
        end
    end

    // Register read mux; also provides the old value for byte-merged writes
    always_comb begin
        w_rd = '0;
        case (s_wb_adr_i)
            c_ADR_CTRL: begin
                w_rd[0] = r_sync_en;
            end
            c_ADR_STATUS: begin
                w_rd[0]    = w_busy;
                w_rd[1]    = r_error;
                w_rd[2]    = r_overrun;
                w_rd[15:8] = r_done_cnt;
            end
            c_ADR_NUM: begin
                w_rd[4:0] = r_num;
            end
            default: begin
                if (w_ent_hit) begin
                    if (w_off[0]) begin
                        w_rd = r_tab_dat[w_ent_idx];
                    end else begin
                        w_rd[WB_ADR_WIDTH-1:0] = r_tab_adr[w_ent_idx];
                        w_rd[19:16]            = r_tab_sel[w_ent_idx];
                    end
                end
            end
        endcase
    end

    assign w_wr_merged = (w_rd & ~w_bmask) | (s_wb_dat_i & w_bmask);
    assign w_num_sat   = (w_wr_merged[4:0] > c_NUM_MAX) ? c_NUM_MAX : w_wr_merged[4:0];

    assign s_wb_ack_o = s_wb_stb_i;
    assign s_wb_dat_o = w_rd;

    // FSM state register
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and datapath control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_wait_clr  = 1'b0;
        w_wait_inc  = 1'b0;
        w_done_inc  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    if (r_num != 5'd0) begin
                        w_state_nxt = S_ISSUE;
                        w_idx_clr   = 1'b1;
                        w_wait_clr  = 1'b1;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_ISSUE: begin
                if (m_wb_ack_i) begin
                    if ((5'(r_index) + 5'd1) >= r_num) begin
                        w_state_nxt = S_IDLE;
                        w_done_inc  = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_idx_inc   = 1'b1;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    // Abort: slave never answered; the rest of the table is dropped
                    w_state_nxt = S_IDLE;
                    w_timeout   = 1'b1;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_ISSUE;
                w_wait_clr  = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_done_inc  = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control/status registers, entry index and ack wait counter
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_sync_en  <= 1'b0;
            r_num      <= 5'd0;
            r_error    <= 1'b0;
            r_overrun  <= 1'b0;
            r_done_cnt <= 8'd0;
            r_index    <= '0;
            r_wait     <= '0;
        end else begin
            if (w_wr && (s_wb_adr_i == c_ADR_CTRL) && s_wb_sel_i[0]) begin
                r_sync_en <= s_wb_dat_i[0];
            end
            if (w_wr && (s_wb_adr_i == c_ADR_NUM) && !w_busy) begin
                r_num <= w_num_sat;
            end
            // A new event in the same cycle as a clear wins, so no event is lost
            r_error   <= (r_error   & ~(w_stat_wr & s_wb_dat_i[1])) | w_timeout;
            r_overrun <= (r_overrun & ~(w_stat_wr & s_wb_dat_i[2])) | (w_trigger & w_busy);
            if (w_done_inc) begin
                r_done_cnt <= r_done_cnt + 8'd1;
            end
            if (w_idx_clr) begin
                r_index <= '0;
            end else if (w_idx_inc) begin
                r_index <= r_index + IDX_W'(1);
            end
            if (w_wait_clr) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + WAIT_W'(1);
            end
        end
    end

    // Write table; frozen while a sequence runs so the issued cycle stays stable
    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            for (int i = 0; i < TABLE_NUM; i++) begin
                r_tab_adr[i] <= '0;
                r_tab_sel[i] <= '0;
                r_tab_dat[i] <= '0;
            end
        end else if (w_wr && w_ent_hit && !w_busy) begin
            if (w_off[0]) begin
                r_tab_dat[w_ent_idx] <= w_wr_merged;
            end else begin
                r_tab_adr[w_ent_idx] <= w_wr_merged[WB_ADR_WIDTH-1:0];
                r_tab_sel[w_ent_idx] <= w_wr_merged[19:16];
            end
        end
    end

    // Master outputs are combinational on state so reset drops them at once
    assign w_sel_wide = {{WB_SEL_WIDTH{1'b0}}, r_tab_sel[r_index]};
    assign m_wb_stb_o = w_issue;
    assign m_wb_we_o  = w_issue;
    assign m_wb_adr_o = w_issue ? r_tab_adr[r_index] : '0;
    assign m_wb_dat_o = w_issue ? r_tab_dat[r_index] : '0;
    assign m_wb_sel_o = w_issue ? w_sel_wide[WB_SEL_WIDTH-1:0] : '0;

    assign busy_o  = w_busy;
    assign error_o = r_error;

endmodule
`default_nettype wire

// File: tb/tb_mnist_param_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_mnist_param_sequencer
// Brief   : Self-checking bench: queue-based bus model plus directed scenarios.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mnist_param_sequencer;

    localparam int TN = 8;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        wb_rst_i;
    logic [7:0]  s_wb_adr_i;
    logic [31:0] s_wb_dat_i;
    logic        s_wb_we_i;
    logic [3:0]  s_wb_sel_i;
    logic        s_wb_stb_i;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_ack_o;
    logic        frame_tuser;
    logic        frame_tvalid;
    logic        frame_tready;
    logic [7:0]  m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic        m_wb_we_o;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_stb_o;
    logic        m_wb_ack_i = 1'b0;
    logic        busy_o;
    logic        error_o;

    always #5 clk = ~clk;

    mnist_param_sequencer #(
        .WB_ADR_WIDTH(8), .WB_DAT_WIDTH(32), .WB_SEL_WIDTH(4),
        .TABLE_NUM(TN), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .wb_rst_i(wb_rst_i),
        .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_we_i(s_wb_we_i),
        .s_wb_sel_i(s_wb_sel_i), .s_wb_stb_i(s_wb_stb_i),
        .s_wb_dat_o(s_wb_dat_o), .s_wb_ack_o(s_wb_ack_o),
        .frame_tuser(frame_tuser), .frame_tvalid(frame_tvalid), .frame_tready(frame_tready),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_we_o(m_wb_we_o),
        .m_wb_sel_o(m_wb_sel_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_ack_i(m_wb_ack_i),
        .busy_o(busy_o), .error_o(error_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- parameter-bus slave: ack on the 3rd strobe clock ----
    bit ack_en  = 1'b1;
    int ack_lat = 2;
    int stb_cnt = 0;
    always @(negedge clk) begin
        if (m_wb_stb_o === 1'b1) begin
            m_wb_ack_i = ack_en && (stb_cnt >= ack_lat);
            stb_cnt++;
        end else begin
            m_wb_ack_i = 1'b0;
            stb_cnt    = 0;
        end
    end

    // ---------------- behavioural model ----------------
    bit        md_sync;
    bit [4:0]  md_num;
    bit        md_err;
    bit        md_ovr;
    bit [7:0]  md_done;
    bit [7:0]  md_tadr [TN];
    bit [3:0]  md_tsel [TN];
    bit [31:0] md_tdat [TN];
    int        md_q[$];
    bit        md_gap;
    bit        md_dpend;
    int        md_wait;

    typedef struct {
        bit [7:0]  a;
        bit [31:0] d;
        bit [3:0]  s;
    } wr_t;
    wr_t wlog[$];
    int  busy_cycles = 0;
    int  stb_cycles  = 0;

    function automatic bit [31:0] md_read(input bit [7:0] a, input bit busy);
        int i;
        if (a == 8'h00) return {31'b0, md_sync};
        if (a == 8'h01) return {16'b0, md_done, 5'b0, md_ovr, md_err, busy};
        if (a == 8'h02) return {27'b0, md_num};
        if (a >= 8'h10 && (int'(a) - 16) / 2 < TN) begin
            i = (int'(a) - 16) / 2;
            if (a[0]) return md_tdat[i];
            return (32'(md_tsel[i]) << 16) | 32'(md_tadr[i]);
        end
        return 32'h0;
    endfunction

    // One compare per cycle, 1 time unit before the rising edge
    always begin : smp
        bit        busy_e, stb_e, wr, kick, frame;
        bit [7:0]  adr_e;
        bit [31:0] dat_e, m, nw;
        bit [3:0]  sel_e;
        int        i;
        @(negedge clk);
        #4;
        if (wb_rst_i !== 1'b1) begin
            md_sync = 0; md_num = 0; md_err = 0; md_ovr = 0; md_done = 0;
            md_q.delete(); md_gap = 0; md_dpend = 0; md_wait = 0;
            for (int k = 0; k < TN; k++) begin
                md_tadr[k] = 0; md_tsel[k] = 0; md_tdat[k] = 0;
            end
            chk("rst_outputs", {m_wb_stb_o, m_wb_we_o, busy_o, error_o, m_wb_sel_o}, 32'h0);
            chk("rst_adr_dat", {m_wb_adr_o, m_wb_dat_o[23:0]} | {24'h0, m_wb_dat_o[31:24]}, 32'h0);
        end else begin
            busy_e = (md_q.size() > 0) || md_dpend;
            stb_e  = (md_q.size() > 0) && !md_gap;
            adr_e = 0; dat_e = 0; sel_e = 0;
            if (stb_e) begin
                i = md_q[0];
                adr_e = md_tadr[i]; dat_e = md_tdat[i]; sel_e = md_tsel[i];
            end
            chk("bus_ctl", {busy_o, m_wb_stb_o, m_wb_we_o, error_o}, {busy_e, stb_e, stb_e, md_err});
            chk("m_adr_sel", {m_wb_adr_o, m_wb_sel_o}, {adr_e, sel_e});
            chk("m_dat", m_wb_dat_o, dat_e);
            chk("s_ack", s_wb_ack_o, s_wb_stb_i);
            if (s_wb_stb_i && !s_wb_we_i)
                chk("s_rdata", s_wb_dat_o, md_read(s_wb_adr_i, busy_e));
            if (busy_o) busy_cycles++;
            if (m_wb_stb_o) stb_cycles++;
            if (m_wb_stb_o && m_wb_ack_i)
                wlog.push_back('{a: m_wb_adr_o, d: m_wb_dat_o, s: m_wb_sel_o});

            // what the coming edge must do, in order: CPU writes, bus progress, trigger
            wr    = s_wb_stb_i && s_wb_we_i;
            kick  = wr && s_wb_adr_i == 8'h00 && s_wb_sel_i[0] && s_wb_dat_i[1];
            frame = md_sync && frame_tvalid && frame_tready && frame_tuser;
            m = 0;
            for (int b = 0; b < 4; b++) if (s_wb_sel_i[b]) m[b*8 +: 8] = 8'hFF;
            nw = (md_read(s_wb_adr_i, busy_e) & ~m) | (s_wb_dat_i & m);
            if (wr && s_wb_sel_i[0] && s_wb_adr_i == 8'h00) md_sync = s_wb_dat_i[0];
            if (wr && s_wb_sel_i[0] && s_wb_adr_i == 8'h01) begin
                if (s_wb_dat_i[1]) md_err = 0;
                if (s_wb_dat_i[2]) md_ovr = 0;
            end
            if (wr && !busy_e && s_wb_adr_i == 8'h02)
                md_num = (nw[4:0] > TN) ? 5'(TN) : nw[4:0];
            if (wr && !busy_e && s_wb_adr_i >= 8'h10 && (int'(s_wb_adr_i) - 16) / 2 < TN) begin
                i = (int'(s_wb_adr_i) - 16) / 2;
                if (s_wb_adr_i[0]) md_tdat[i] = nw;
                else begin
                    md_tadr[i] = nw[7:0];
                    md_tsel[i] = nw[19:16];
                end
            end
            if (md_dpend) begin
                md_dpend = 0;
                md_done++;
            end else if (md_gap) begin
                md_gap = 0;
            end else if (stb_e) begin
                if (m_wb_ack_i) begin
                    void'(md_q.pop_front());
                    md_wait = 0;
                    if (md_q.size() == 0) md_done++;
                    else md_gap = 1;
                end else if (md_wait == TO - 1) begin
                    md_q.delete();
                    md_err = 1;
                end else begin
                    md_wait++;
                end
            end
            if (kick || frame) begin
                if (busy_e) md_ovr = 1;
                else if (md_num > 0) begin
                    for (int k = 0; k < int'(md_num); k++) md_q.push_back(k);
                    md_wait = 0;
                    md_gap  = 0;
                end else md_dpend = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wb_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        s_wb_adr_i = a; s_wb_dat_i = d; s_wb_sel_i = s; s_wb_we_i = 1'b1; s_wb_stb_i = 1'b1;
        @(negedge clk);
        s_wb_stb_i = 1'b0; s_wb_we_i = 1'b0; s_wb_sel_i = 4'h0;
    endtask

    task automatic wb_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        s_wb_adr_i = a; s_wb_sel_i = 4'hF; s_wb_we_i = 1'b0; s_wb_stb_i = 1'b1;
        #1 d = s_wb_dat_o;
        @(negedge clk);
        s_wb_stb_i = 1'b0; s_wb_sel_i = 4'h0;
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        frame_tvalid = 1'b1; frame_tready = 1'b1; frame_tuser = 1'b1;
        @(negedge clk);
        frame_tvalid = 1'b0; frame_tready = 1'b0; frame_tuser = 1'b0;
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_o && n < bound);
        chk(name, busy_o, 1'b0);
    endtask

    // global time limit
    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    logic [31:0] rd;
    int          n;

    initial begin
        wb_rst_i = 1'b0;
        s_wb_adr_i = 0; s_wb_dat_i = 0; s_wb_we_i = 0; s_wb_sel_i = 0; s_wb_stb_i = 0;
        frame_tuser = 0; frame_tvalid = 0; frame_tready = 0;
        repeat (3) @(negedge clk);
        chk("reset_stb", m_wb_stb_o, 1'b0);
        chk("reset_busy_err", {busy_o, error_o}, 2'b00);
        wb_rst_i = 1'b1;
        wb_rd(8'h01, rd); chk("reset_status", rd, 32'h0);
        wb_rd(8'h02, rd); chk("reset_num", rd, 32'h0);

        // three-entry table, kick
        wb_wr(8'h10, 32'h000F_0004, 4'hF); wb_wr(8'h11, 32'h0000_007F, 4'hF);
        wb_wr(8'h12, 32'h0001_0005, 4'hF); wb_wr(8'h13, 32'h0000_0001, 4'hF);
        wb_wr(8'h14, 32'h000F_0040, 4'hF); wb_wr(8'h15, 32'h0000_0010, 4'hF);
        wb_wr(8'h02, 32'd3, 4'hF);
        wlog.delete(); busy_cycles = 0; stb_cycles = 0;
        wb_wr(8'h00, 32'h2, 4'hF);
        wait_idle(100, "seq3_timeout");
        chk("seq3_nwrites", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("seq3_w0", {wlog[0].a, wlog[0].d[19:0], wlog[0].s}, {8'h04, 20'h7F, 4'hF});
            chk("seq3_w1", {wlog[1].a, wlog[1].d[19:0], wlog[1].s}, {8'h05, 20'h01, 4'h1});
            chk("seq3_w2", {wlog[2].a, wlog[2].d[19:0], wlog[2].s}, {8'h40, 20'h10, 4'hF});
        end
        chk("seq3_busy_cycles", busy_cycles, 11);
        chk("seq3_stb_cycles", stb_cycles, 9);
        wb_rd(8'h01, rd); chk("seq3_status", rd, 32'h0000_0100);

        // byte selects, NUM saturation, unmapped reads
        wb_wr(8'h17, 32'hAABB_CCDD, 4'hF);
        wb_wr(8'h17, 32'h1122_3344, 4'b0010);
        wb_rd(8'h17, rd); chk("byte_sel", rd, 32'hAABB_33DD);
        wb_wr(8'h02, 32'd20, 4'hF);
        wb_rd(8'h02, rd); chk("num_saturate", rd, 32'd8);
        wb_wr(8'h02, 32'd3, 4'hF);
        wb_rd(8'h05, rd); chk("unmapped_05", rd, 32'h0);
        wb_rd(8'h30, rd); chk("unmapped_30", rd, 32'h0);

        // frame-synchronous triggering
        wb_wr(8'h00, 32'h1, 4'hF);
        frame_pulse(); wait_idle(100, "sync1_timeout");
        repeat (5) @(negedge clk);
        frame_pulse(); wait_idle(100, "sync2_timeout");
        wb_wr(8'h00, 32'h0, 4'hF);
        wb_rd(8'h01, rd); chk("sync_status", rd, 32'h0000_0300);

        // overrun: second kick and NUM write while busy
        wlog.delete();
        wb_wr(8'h00, 32'h2, 4'hF);
        wb_wr(8'h00, 32'h2, 4'hF);
        wb_wr(8'h02, 32'd1, 4'hF);
        wait_idle(100, "ovr_timeout");
        chk("ovr_nwrites", wlog.size(), 3);
        wb_rd(8'h02, rd); chk("ovr_num_kept", rd, 32'd3);
        wb_rd(8'h01, rd); chk("ovr_status", rd, 32'h0000_0404);
        wb_wr(8'h01, 32'h4, 4'hF);
        wb_rd(8'h01, rd); chk("ovr_cleared", rd, 32'h0000_0400);

        // slave never acks -> abort after TIMEOUT clocks
        ack_en = 1'b0; wlog.delete(); stb_cycles = 0;
        wb_wr(8'h00, 32'h2, 4'hF);
        wait_idle(400, "to_timeout");
        chk("to_stb_cycles", stb_cycles, 255);
        chk("to_error", error_o, 1'b1);
        chk("to_nwrites", wlog.size(), 0);
        wb_rd(8'h01, rd); chk("to_status", rd, 32'h0000_0402);
        wb_wr(8'h01, 32'h2, 4'hF);
        chk("to_err_clear", error_o, 1'b0);
        ack_en = 1'b1;

        // NUM = 0
        wb_wr(8'h02, 32'd0, 4'hF);
        busy_cycles = 0; stb_cycles = 0;
        wb_wr(8'h00, 32'h2, 4'hF);
        repeat (3) @(negedge clk);
        chk("num0_busy_cycles", busy_cycles, 1);
        chk("num0_stb_cycles", stb_cycles, 0);
        wb_rd(8'h01, rd); chk("num0_status", rd, 32'h0000_0500);

        // reset during the issue of entry 1
        wb_wr(8'h02, 32'd3, 4'hF);
        wb_wr(8'h00, 32'h2, 4'hF);
        n = 0;
        while (!(m_wb_stb_o && m_wb_adr_o == 8'h05) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached", {m_wb_stb_o, m_wb_adr_o}, {1'b1, 8'h05});
        wb_rst_i = 1'b0;
        #1;
        chk("rst_mid_stb_drop", m_wb_stb_o, 1'b0);
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b1;
        stb_cycles = 0;
        repeat (20) @(negedge clk);
        chk("rst_mid_no_bus", stb_cycles, 0);
        wb_rd(8'h02, rd); chk("rst_mid_num", rd, 32'h0);
        wb_rd(8'h10, rd); chk("rst_mid_entry0", rd, 32'h0);
        wb_rd(8'h01, rd); chk("rst_mid_status", rd, 32'h0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
